rgb_gray_reader: RTL and testbench

//  Reader end of the RWM_1 pixel-memory interface: consumes the R,G,B byte stream RWM_1 drives in READ,

---
 rtl/rgb_gray_if.sv | 20 ++
 rtl/rgb_gray_reader.sv | 148 ++++++++++++++
 tb/tb_rgb_gray_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_gray_if.sv
// Pixel-stream interface between the RWM_1 byte source, the gray converter and its downstream consumer.
// The master side drives bytes and out_ready; the slave side is the converter.
interface rgb_gray_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       pause;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  pause, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output pause, out_data, out_valid
  );
endinterface

// File: rtl/rgb_gray_reader.sv
// Reads the R,G,B byte stream from RWM_1, converts each triplet to an 8-bit luma value and
// buffers it in a small FIFO with pause-based back-pressure and frame-done signalling.
module rgb_gray_reader #(
  parameter int unsigned N          = 2,
  parameter int unsigned M          = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CR         = 77,
  parameter int unsigned CG         = 150,
  parameter int unsigned CB         = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  rgb_gray_if.slave    bus,
  output logic         busy,
  output logic         gray_done,
  output logic         err_overflow
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned PIX = N * M;
  localparam int unsigned XW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HIGH_C  = CW'(FIFO_DEPTH - 1);
  localparam logic [XW-1:0] LAST_C  = XW'(PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Weighted sum fits 16 bits because the coefficients add up to 256; the top byte is the luma.
  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [15:0] sum;
    sum = (16'(CR) * {8'd0, r}) + (16'(CG) * {8'd0, g}) + (16'(CB) * {8'd0, b});
    return sum[15:8];
  endfunction

  state_t          state_r, state_nxt_s;
  logic [1:0]      phase_r;
  logic [7:0]      r_r, g_r;
  logic [XW-1:0]   pix_cnt_r;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [CW-1:0]   count_r, count_nxt_s;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [7:0]      gray_s, head_nxt_s;
  logic            out_valid_r, pause_r, busy_r, gray_done_r, err_r;
  logic [7:0]      out_data_r;
  logic            take_s, b_byte_s, pop_s, full_s, push_s, drop_s, stray_s, last_pix_s;

  assign take_s     = bus.in_valid && (state_r == S_RUN);
  assign stray_s    = bus.in_valid && (state_r != S_RUN);
  assign b_byte_s   = take_s && (phase_r == 2'd2);
  assign pop_s      = out_valid_r && bus.out_ready;
  assign full_s     = (count_r == DEPTH_C);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s     = b_byte_s && (!full_s || pop_s);
  assign drop_s     = b_byte_s && full_s && !pop_s;
  assign last_pix_s = b_byte_s && (pix_cnt_r == LAST_C);
  assign gray_s     = luma(r_r, g_r, bus.in_data);

  // Frame sequencing: IDLE -> RUN on start, RUN -> DRAIN on last pixel, DRAIN -> IDLE when empty.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_RUN;
        else       state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (last_pix_s) state_nxt_s = S_DRAIN;
        else            state_nxt_s = S_RUN;
      end
      S_DRAIN: begin
        if (count_r == {CW{1'b0}}) state_nxt_s = S_IDLE;
        else                       state_nxt_s = S_DRAIN;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next FIFO occupancy, read pointer and the value that will sit at the head after this edge.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    else       rd_ptr_nxt_s = rd_ptr_r;
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) head_nxt_s = gray_s;
    else                                      head_nxt_s = mem_r[rd_ptr_nxt_s];
  end

  // FIFO storage; contents need no reset since out_valid gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= gray_s;
  end

  // Control state, byte assembly, FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      phase_r     <= 2'd0;
      r_r         <= 8'd0;
      g_r         <= 8'd0;
      pix_cnt_r   <= {XW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      pause_r     <= 1'b0;
      busy_r      <= 1'b0;
      gray_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (take_s) begin
        phase_r <= (phase_r == 2'd2) ? 2'd0 : phase_r + 2'd1;
        if (phase_r == 2'd0) r_r <= bus.in_data;
        if (phase_r == 2'd1) g_r <= bus.in_data;
      end
      if (b_byte_s) pix_cnt_r <= last_pix_s ? {XW{1'b0}} : pix_cnt_r + XW'(1);
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      if (count_nxt_s != {CW{1'b0}}) out_data_r <= head_nxt_s;
      // One slot of headroom absorbs the byte RWM_1 still sends in the cycle pause rises.
      pause_r     <= (state_nxt_s == S_RUN) && (count_nxt_s >= HIGH_C);
      busy_r      <= (state_nxt_s != S_IDLE);
      gray_done_r <= (state_r == S_DRAIN) && (count_r != {CW{1'b0}}) && (count_nxt_s == {CW{1'b0}});
      if (drop_s || stray_s) err_r <= 1'b1;
    end
  end

  assign bus.pause     = pause_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign busy          = busy_r;
  assign gray_done     = gray_done_r;
  assign err_overflow  = err_r;

endmodule

// File: tb/tb_rgb_gray_reader.sv
// Directed bench for rgb_gray_reader: 2x3 frames (six pixels) with a 4-entry FIFO, hand-computed luma values.
module tb_rgb_gray_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, gray_done, err_overflow;

  rgb_gray_if bus();

  rgb_gray_reader #(.N(2), .M(3), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .gray_done    (gray_done),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -10;
  int last_pop_cyc = -20;
  int pause_cnt = 0;
  logic [7:0] got_q[$];

  // Output monitor: records every accepted byte, done pulses and cycles with pause high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got_q.push_back(bus.out_data);
      last_pop_cyc <= cyc;
    end
    if (gray_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.pause === 1'b1) pause_cnt <= pause_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
  endtask

  task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send_byte(r);
    send_byte(g);
    send_byte(b);
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp [6]);
    check_eq({tag, "_count"}, got_q.size(), base + 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < got_q.size())
        check_eq($sformatf("%s_px%0d", tag, i), got_q[base + i], exp[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pause"}, bus.pause, 0);
    check_eq({tag, "_oval"}, bus.out_valid, 0);
    check_eq({tag, "_odata"}, bus.out_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, gray_done, 0);
    check_eq({tag, "_err"}, err_overflow, 0);
  endtask

  logic [7:0] exp_a [6] = '{8'd255, 8'd0, 8'd76, 8'd149, 8'd18, 8'd1};
  logic [7:0] exp_b [6] = '{8'd100, 8'd200, 8'd28, 8'd90, 8'd226, 8'd178};
  logic [7:0] exp_d [6] = '{8'd76, 8'd149, 8'd255, 8'd0, 8'd18, 8'd1};

  initial begin
    int base, d0, p0, d_pre;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Frame A: free-flowing output, latency and done-pulse timing.
    bus.out_ready = 1'b1;
    base = got_q.size();
    d0 = done_cnt;
    p0 = pause_cnt;
    do_start("a");
    send_pix(8'd255, 8'd255, 8'd255);
    check_eq("a_lat_pre", bus.out_valid, 0);
    @(negedge clk);
    check_eq("a_lat_valid", bus.out_valid, 1);
    check_eq("a_lat_data", bus.out_data, 255);
    bus.in_valid = 1'b0;
    send_pix(8'd0, 8'd0, 8'd0);
    send_pix(8'd255, 8'd0, 8'd0);
    send_pix(8'd0, 8'd255, 8'd0);
    send_pix(8'd10, 8'd20, 8'd30);
    send_pix(8'd1, 8'd2, 8'd3);
    idle_in();
    wait_idle("a");
    check_frame("a", base, exp_a);
    check_eq("a_done_cnt", done_cnt - d0, 1);
    check_eq("a_done_lag", done_cyc - last_pop_cyc, 1);
    check_eq("a_no_pause", pause_cnt - p0, 0);
    check_eq("a_err", err_overflow, 0);

    // Frame B: stalled output fills the FIFO, pause, push+pop while full, then release.
    bus.out_ready = 1'b0;
    base = got_q.size();
    d0 = done_cnt;
    do_start("b");
    send_pix(8'd100, 8'd100, 8'd100);
    send_pix(8'd200, 8'd200, 8'd200);
    send_byte(8'd0);
    check_eq("b_pause_at2", bus.pause, 0);
    send_byte(8'd0);
    send_byte(8'd255);
    @(negedge clk);
    check_eq("b_pause_at3", bus.pause, 1);
    bus.in_data = 8'd50;
    send_byte(8'd100);
    send_byte(8'd150);
    @(negedge clk);
    check_eq("b_pause_full", bus.pause, 1);
    check_eq("b_err_full", err_overflow, 0);
    check_eq("b_oval_full", bus.out_valid, 1);
    check_eq("b_head_full", bus.out_data, 100);
    bus.in_data = 8'd255;
    send_byte(8'd255);
    @(negedge clk);
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("b_pushpop_err", err_overflow, 0);
    check_eq("b_pushpop_pause", bus.pause, 1);
    check_eq("b_pushpop_pops", got_q.size(), base + 1);
    check_eq("b_pushpop_head", bus.out_data, 200);
    send_byte(8'd0);
    send_byte(8'd255);
    check_eq("b_pause_drop", bus.pause, 0);
    send_byte(8'd255);
    idle_in();
    wait_idle("b");
    check_frame("b", base, exp_b);
    check_eq("b_done_cnt", done_cnt - d0, 1);
    check_eq("b_err", err_overflow, 0);
    check_eq("b_pause_end", bus.pause, 0);

    // Frame C: reset after five bytes abandons the frame without a done pulse.
    d_pre = done_cnt;
    do_start("c");
    send_pix(8'd10, 8'd20, 8'd30);
    send_byte(8'd40);
    send_byte(8'd50);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("c_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame D: clean frame after reset, with a start pulse during RUN that must be ignored.
    base = got_q.size();
    do_start("d");
    send_pix(8'd255, 8'd0, 8'd0);
    send_byte(8'd0);
    start = 1'b1;
    send_byte(8'd255);
    start = 1'b0;
    send_byte(8'd0);
    send_pix(8'd255, 8'd255, 8'd255);
    send_pix(8'd0, 8'd0, 8'd0);
    send_pix(8'd10, 8'd20, 8'd30);
    send_pix(8'd1, 8'd2, 8'd3);
    idle_in();
    wait_idle("d");
    check_frame("d", base, exp_d);
    check_eq("d_done_cnt", done_cnt - d_pre, 1);
    check_eq("d_err", err_overflow, 0);

    // Stray byte while IDLE sets the sticky error until reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("e_err_set", err_overflow, 1);
    repeat (3) @(negedge clk);
    check_eq("e_err_sticky", err_overflow, 1);
    rst_n = 1'b0;
    #1;
    check_eq("e_err_rst", err_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
